// File: rtl/bus_w_pkg.sv
// Shared types and helpers for the registered W-bus sequencer.
// Mode and state encodings are used by both the top level and the bench.
package bus_w_pkg;

  typedef enum logic [1:0] {
    W_PASS = 2'd0,
    W_HOLD = 2'd1,
    W_PACK = 2'd2,
    W_RSVD = 2'd3
  } w_mode_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_HALF = 1'b1
  } w_state_e;

  function automatic int half_w(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/bus_w_if.sv
// W-bus sequencer signal bundle: source/control from the master, registered W back.
interface bus_w_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8,
  parameter int SELW  = $clog2(NSRC)
) ();

  logic [NSRC*WIDTH-1:0] src;
  logic [SELW-1:0]       sel;
  logic                  blank_hi;
  logic                  blank_lo;
  logic                  swap;
  logic [1:0]            mode;
  logic                  strobe;
  logic                  abort;
  logic [WIDTH-1:0]      w;
  logic                  w_valid;
  logic                  busy;

  modport master (
    output src, sel, blank_hi, blank_lo, swap, mode, strobe, abort,
    input  w, w_valid, busy
  );

  modport slave (
    input  src, sel, blank_hi, blank_lo, swap, mode, strobe, abort,
    output w, w_valid, busy
  );

endinterface

// File: rtl/bus_w_form.sv
// Combinational word former: source select (out-of-range reads as zero), swap, blanking.
// The upper half is the MSB half, i.e. bits [WIDTH-1:WIDTH/2] in Verilog numbering.
module bus_w_form
  import bus_w_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic [NSRC*WIDTH-1:0] src,
  input  logic [SELW-1:0]       sel,
  input  logic                  blank_hi,
  input  logic                  blank_lo,
  input  logic                  swap,
  output logic [WIDTH-1:0]      f
);

  localparam int HALF = half_w(WIDTH);

  logic [WIDTH-1:0] s;

  always_comb begin
    // selects past NSRC match no source and leave s at zero
    s = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) s = src[k*WIDTH +: WIDTH];
    end
    f = s;
    if (swap)     f = {{HALF{1'b0}}, s[WIDTH-1:HALF]};
    if (blank_hi) f[WIDTH-1:HALF] = '0;
    if (blank_lo) f[HALF-1:0] = '0;
  end

endmodule

// File: rtl/bus_w_seq.sv
// Registered W-bus multiplexer with a two-beat PACK sequencer.
//   state  | meaning
//   W_IDLE | no half captured; PASS loads directly, PACK captures the high half
//   W_HALF | high half held in acc_hi; next PACK strobe completes the word
module bus_w_seq
  import bus_w_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8
) (
  input logic   clk_sys,
  input logic   rst,
  bus_w_if.slave bus
);

  localparam int SELW = $clog2(NSRC);
  localparam int HALF = half_w(WIDTH);

  logic [WIDTH-1:0] f;
  w_state_e         state_q, state_d;
  logic [HALF-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             valid_q, valid_d;

  bus_w_form #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_form (
    .src      (bus.src),
    .sel      (bus.sel),
    .blank_hi (bus.blank_hi),
    .blank_lo (bus.blank_lo),
    .swap     (bus.swap),
    .f        (f)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= W_IDLE;
      acc_q   <= '0;
      w_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    w_d     = w_q;
    valid_d = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (bus.strobe && bus.mode == W_PASS) begin
          w_d     = f;
          valid_d = 1'b1;
        end else if (bus.strobe && bus.mode == W_PACK) begin
          acc_d   = f[HALF-1:0];
          state_d = W_HALF;
        end
      end
      W_HALF: begin
        // leaving PACK or aborting cancels the word and swallows any strobe
        if (bus.abort || bus.mode != W_PACK) begin
          acc_d   = '0;
          state_d = W_IDLE;
        end else if (bus.strobe) begin
          w_d     = {acc_q, f[HALF-1:0]};
          valid_d = 1'b1;
          acc_d   = '0;
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign bus.w       = w_q;
  assign bus.w_valid = valid_q;
  assign bus.busy    = (state_q == W_HALF);

endmodule

// File: tb/tb_bus_w_seq.sv
// Bench for bus_w_seq: two instances (NSRC=8 and NSRC=5) share stimulus and are
// compared every cycle against a word-level model, plus directed literal checks.
module tb_bus_w_seq;

  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  bus_w_if #(.WIDTH(16), .NSRC(8)) i8 ();
  bus_w_if #(.WIDTH(16), .NSRC(5)) i5 ();

  bus_w_seq #(.WIDTH(16), .NSRC(8)) u8 (.clk_sys(clk_sys), .rst(rst), .bus(i8));
  bus_w_seq #(.WIDTH(16), .NSRC(5)) u5 (.clk_sys(clk_sys), .rst(rst), .bus(i5));

  logic [15:0] srcv [8];
  logic [2:0]  sel;
  logic        bh, bl, sw, strobe, abort;
  logic [1:0]  mode;

  int errors = 0;
  int checks = 0;

  // model state per instance: 0 -> NSRC=8, 1 -> NSRC=5
  logic [15:0] m_w     [2];
  logic        m_valid [2];
  logic        m_pend  [2];
  logic [7:0]  m_acc   [2];
  int          nsrc    [2] = '{8, 5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] formed(input int ns);
    logic [15:0] v;
    v = (int'(sel) < ns) ? srcv[sel] : 16'h0000;
    if (sw) v = v >> 8;
    if (bh) v = v & 16'h00FF;
    if (bl) v = v & 16'hFF00;
    return v;
  endfunction

  task automatic model_step(input int d);
    logic [15:0] fv;
    fv = formed(nsrc[d]);
    if (rst) begin
      m_w[d] = 16'h0; m_valid[d] = 1'b0; m_pend[d] = 1'b0; m_acc[d] = 8'h0;
    end else begin
      m_valid[d] = 1'b0;
      if (m_pend[d]) begin
        if (abort || mode != 2'd2) m_pend[d] = 1'b0;
        else if (strobe) begin
          m_w[d] = {m_acc[d], fv[7:0]};
          m_valid[d] = 1'b1;
          m_pend[d] = 1'b0;
        end
      end else if (strobe && mode == 2'd0) begin
        m_w[d] = fv;
        m_valid[d] = 1'b1;
      end else if (strobe && mode == 2'd2) begin
        m_acc[d] = fv[7:0];
        m_pend[d] = 1'b1;
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 8; k++) i8.src[k*16 +: 16] = srcv[k];
    for (int k = 0; k < 5; k++) i5.src[k*16 +: 16] = srcv[k];
    i8.sel = sel;  i5.sel = sel;
    i8.blank_hi = bh; i5.blank_hi = bh;
    i8.blank_lo = bl; i5.blank_lo = bl;
    i8.swap = sw;  i5.swap = sw;
    i8.mode = mode; i5.mode = mode;
    i8.strobe = strobe; i5.strobe = strobe;
    i8.abort = abort; i5.abort = abort;
  endtask

  // one clock: apply inputs, advance model, compare both instances after the edge
  task automatic cyc();
    drive();
    @(posedge clk_sys);
    #1;
    model_step(0);
    model_step(1);
    chk("w8",       32'(i8.w),       32'(m_w[0]));
    chk("w_valid8", 32'(i8.w_valid), 32'(m_valid[0]));
    chk("busy8",    32'(i8.busy),    32'(m_pend[0]));
    chk("w5",       32'(i5.w),       32'(m_w[1]));
    chk("w_valid5", 32'(i5.w_valid), 32'(m_valid[1]));
    chk("busy5",    32'(i5.busy),    32'(m_pend[1]));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) srcv[k] = 16'(k * 16'h1111);
    for (int d = 0; d < 2; d++) begin
      m_w[d] = 16'h0; m_valid[d] = 1'b0; m_pend[d] = 1'b0; m_acc[d] = 8'h0;
    end
    bh = 0; bl = 0; sw = 0; abort = 0;

    // reset overrides a held PASS strobe
    rst = 1; srcv[3] = 16'hA55A; mode = 2'd0; sel = 3'd3; strobe = 1;
    cyc(); cyc();
    chk("rst_w",     32'(i8.w),       32'h0);
    chk("rst_valid", 32'(i8.w_valid), 32'h0);
    chk("rst_busy",  32'(i8.busy),    32'h0);
    rst = 0;
    cyc();
    chk("rel_w",     32'(i8.w),       32'hA55A);
    chk("rel_valid", 32'(i8.w_valid), 32'h1);

    // swap and blanking in PASS
    srcv[6] = 16'h12F0; sel = 3'd6; sw = 1;
    cyc(); chk("swap", 32'(i8.w), 32'h0012);
    bl = 1;
    cyc(); chk("swap_blank_lo", 32'(i8.w), 32'h0000);
    bl = 0; sw = 0; sel = 3'd7; srcv[7] = 16'hFFFF; bh = 1;
    cyc(); chk("blank_hi", 32'(i8.w), 32'h00FF);
    bh = 0;

    // PACK back-to-back
    mode = 2'd2; srcv[2] = 16'h0034; srcv[5] = 16'h0078; sel = 3'd2;
    cyc();
    chk("pack1_busy",  32'(i8.busy),    32'h1);
    chk("pack1_valid", 32'(i8.w_valid), 32'h0);
    chk("pack1_w",     32'(i8.w),       32'h00FF);
    sel = 3'd5;
    cyc();
    chk("pack2_w",     32'(i8.w),       32'h3478);
    chk("pack2_valid", 32'(i8.w_valid), 32'h1);
    chk("pack2_busy",  32'(i8.busy),    32'h0);
    strobe = 0;
    cyc(); chk("pack_pulse_end", 32'(i8.w_valid), 32'h0);

    // PACK abort beats a simultaneous strobe
    srcv[5] = 16'h0099; strobe = 1; sel = 3'd2;
    cyc(); chk("ab_busy1", 32'(i8.busy), 32'h1);
    abort = 1; sel = 3'd5;
    cyc();
    chk("ab_busy",  32'(i8.busy),    32'h0);
    chk("ab_valid", 32'(i8.w_valid), 32'h0);
    chk("ab_w",     32'(i8.w),       32'h3478);
    abort = 0;
    cyc(); chk("ab_restart", 32'(i8.busy), 32'h1);
    sel = 3'd2;
    cyc(); chk("ab_after_w", 32'(i8.w), 32'h9934);

    // mode change while HALF
    sel = 3'd2;
    cyc(); chk("mc_busy1", 32'(i8.busy), 32'h1);
    mode = 2'd0; strobe = 0;
    cyc();
    chk("mc_busy", 32'(i8.busy), 32'h0);
    chk("mc_w",    32'(i8.w),    32'h9934);
    strobe = 1; sel = 3'd6;
    cyc(); chk("mc_pass", 32'(i8.w), 32'h12F0);

    // HOLD and reserved mode ignore strobes
    for (int i = 0; i < 10; i++) begin
      mode = (i < 5) ? 2'd1 : 2'd3;
      sel = 3'(i);
      cyc();
      chk("hold_w",     32'(i8.w),       32'h12F0);
      chk("hold_valid", 32'(i8.w_valid), 32'h0);
    end

    // out-of-range select on the NSRC=5 instance
    mode = 2'd0; sel = 3'd3;
    cyc(); chk("oor_pre", 32'(i5.w), 32'hA55A);
    sel = 3'd6;
    cyc();
    chk("oor_w",     32'(i5.w),       32'h0000);
    chk("oor_valid", 32'(i5.w_valid), 32'h1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 8; k++) srcv[k] = 16'($urandom);
      sel    = 3'($urandom_range(0, 7));
      bh     = ($urandom_range(0, 5) == 0);
      bl     = ($urandom_range(0, 5) == 0);
      sw     = ($urandom_range(0, 3) == 0);
      mode   = ($urandom_range(0, 9) < 6) ? 2'd2 : 2'($urandom_range(0, 3));
      strobe = ($urandom_range(0, 9) < 7);
      abort  = ($urandom_range(0, 9) < 1);
      rst    = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_w_seq.md
# bus_w_seq

Registered, parametrised successor to the processor's internal W-bus multiplexer. It selects one of NSRC equal-width sources, applies half-word blanking and high-to-low half transfer, and registers the result. Its PACK mode is a two-beat sequencer that assembles a word from the low halves of two successive selections, for byte-oriented memory and I/O transfers. It sits between the register file, AC/AT/A/KI/IR sources and the W consumers, replacing the transparent mux where a stable, strobed W value is required.

## Interface
- WIDTH, 16, W-bus width in bits; even, at least 8. Bits are numbered MSB-first, 0 to WIDTH-1.
- NSRC, 8, number of sources.
- SELW, $clog2(NSRC), select width.
- clk_sys  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- src  in  NSRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SELW  source select.
- blank_hi  in  1  force upper half (bits 0 to WIDTH/2-1) of the formed word to 0.
- blank_lo  in  1  force lower half of the formed word to 0.
- swap  in  1  transfer the source's upper half to the lower half, with the upper half set to 0.
- mode  in  2  operating mode: 0 PASS, 1 HOLD, 2 PACK, 3 reserved (treated as HOLD).
- strobe  in  1  load request.
- abort  in  1  cancel an in-progress PACK sequence.
- w  out  WIDTH  registered W bus.
- w_valid  out  1  one-cycle pulse when w is updated.
- busy  out  1  PACK sequence has its first half captured.

## Operation
- The formed word F is built from S = src[sel] in this order:
  - If sel ≥ NSRC, then S = 0.
  - If swap is set, F = {0, S.upper}; otherwise F = S.
  - blank_hi zeroes F.upper; blank_lo zeroes F.lower. Blanking is applied after swap.
- PASS: when strobe is set, w ← F and w_valid pulses. When strobe is clear, w holds.
- HOLD (and reserved mode 3): w holds and strobe is ignored.
- PACK uses a state machine with states IDLE and HALF.
  - IDLE, strobe set: acc_hi ← F.lower and the state moves to HALF. busy is 1 from the next cycle. w does not change.
  - HALF, strobe set: w ← {acc_hi, F.lower}, w_valid pulses, and the state returns to IDLE.
  - In PACK, blank and swap act on F before the lower half is taken.
- Abort conditions:
  - In HALF, abort set or mode ≠ PACK sends the state to IDLE. w is unchanged, acc_hi is discarded, and a strobe in that cycle is ignored.
  - Abort and strobe in the same cycle: abort wins.
  - A mode change while in IDLE needs no cleanup.
- abort has no effect outside HALF.
- All arithmetic is width-exact: there is no carry and no sign extension.

## Timing
- Reset values: w = 0, w_valid = 0, busy = 0, state IDLE, acc_hi = 0. Reset overrides strobe and abort in the same cycle.
- Latency:
  - PASS: strobe at edge N gives w valid and w_valid = 1 after edge N.
  - PACK: the second strobe gives the same timing; the first strobe gives busy = 1 after its edge.
- w_valid is high for exactly one cycle per update. Back-to-back strobes in PASS produce back-to-back updates and a w_valid that stays high.
- The PACK throughput limit is one word per two strobes. Strobes may be on consecutive cycles.
- All inputs are sampled at the rising edge of clk_sys. There are no combinational paths from inputs to outputs.

## Structure
- Package bus_w_pkg holds:
  - mode constants W_PASS, W_HOLD, W_PACK;
  - state encoding W_IDLE, W_HALF;
  - the half-width localparam helper.
- Sub-module bus_w_form is the combinational word former: source select, out-of-range zero, swap and blanking. It is instantiated once.
- The top level holds the registers, the PACK FSM and the valid/busy logic.

## Test plan
- Reset with WIDTH=16, NSRC=8, src[3]=16'hA55A, mode=PASS, sel=3, strobe held: while rst=1, w=0 and w_valid=0. First cycle after release: w=16'hA55A and w_valid=1.
- PASS with swap=1, src[6]=16'h12F0: w=16'h0012. Adding blank_lo=1 gives w=16'h0000. sel=7 with src[7]=16'hFFFF and blank_hi=1 gives w=16'h00FF.
- PACK, back-to-back strobes: strobe with src[2]=16'h0034, then strobe with src[5]=16'h0078. Expect busy=1 for one cycle, then w=16'h3478 with a single w_valid pulse.
- PACK abort: first strobe (acc_hi=8'h34), then abort together with strobe. Expect state IDLE, busy=0, w unchanged, no w_valid. A following strobe is treated as a first half.
- Mode change in HALF (PACK→PASS) with no strobe: busy drops, w unchanged. Next PASS strobe loads F directly. In HOLD, 10 strobes give no w change and no w_valid.
- Out of range with NSRC=5, sel=6, PASS strobe: w=0 and w_valid=1.
